// File: rtl/ip_rx_stream_parser_pkg.sv
// ip_rx_stream_parser_pkg: shared states, IPv4 header offsets and helpers.
// Used by ip_rx_stream_parser and ip_csum_acc.
package ip_rx_stream_parser_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_PAY  = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

    localparam logic [3:0] IPV4_VERSION = 4'd4;
    localparam logic [3:0] IHL_MIN      = 4'd5;

    localparam logic [5:0] OFF_TOTLEN = 6'd2;
    localparam logic [5:0] OFF_IDENT  = 6'd4;
    localparam logic [5:0] OFF_FLAGS  = 6'd6;
    localparam logic [5:0] OFF_PROTO  = 6'd9;
    localparam logic [5:0] OFF_CSUM   = 6'd10;
    localparam logic [5:0] OFF_SRC    = 6'd12;
    localparam logic [5:0] OFF_DST    = 6'd16;
    localparam logic [5:0] HDR_LAST   = 6'd19;

    function automatic logic [15:0] ones_add(
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

endpackage

// File: rtl/ip_rx_stream_parser_csum_acc.sv
// ip_csum_acc: byte-serial 16-bit ones-complement header checksum.
// sum_ok already includes the low byte presented this cycle.
module ip_csum_acc
    import ip_rx_stream_parser_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] data,
    output logic       sum_ok
);

    logic [15:0] acc;
    logic [7:0]  hi;
    logic        phase;
    logic [15:0] acc_base;
    logic        phase_eff;
    logic [15:0] acc_next;

    assign acc_base  = clr ? 16'd0 : acc;
    assign phase_eff = clr ? 1'b0 : phase;
    assign acc_next  = ones_add(acc_base, {hi, data});
    assign sum_ok    = phase_eff && (acc_next == 16'hFFFF);

    // Pair bytes into words (high byte first) and fold each word in
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc   <= 16'd0;
            hi    <= 8'd0;
            phase <= 1'b0;
        end else if (en) begin
            if (phase_eff) begin
                acc   <= acc_next;
                phase <= 1'b0;
            end else begin
                acc   <= acc_base;
                hi    <= data;
                phase <= 1'b1;
            end
        end else if (clr) begin
            acc   <= 16'd0;
            phase <= 1'b0;
        end
    end

endmodule

// File: rtl/ip_rx_stream_parser.sv
// ip_rx_stream_parser: byte-stream IPv4 header filter/stripper, L4 out.
// Define IP_RX_CSUM_CHECK_EN to enable header checksum checking.
module ip_rx_stream_parser
    import ip_rx_stream_parser_pkg::*;
#(
    parameter logic [7:0]  PROTOCOL = 8'd6,
    parameter logic [31:0] DESADDR  = 32'hc0a84103,
    parameter logic [31:0] SRCADDR  = 32'hc0a84104,
    parameter bit          SRC_FILT = 1'b0,
    parameter logic [15:0] MAX_LEN  = 16'd1500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    output logic        m_err,
    input  logic        m_ready,
    output logic        hdr_valid,
    output logic [31:0] hdr_src,
    output logic [15:0] hdr_ident,
    output logic [15:0] hdr_l4_len,
    output logic [15:0] ok_cnt,
    output logic [15:0] drop_cnt
);

    logic [1:0]  state;
    logic [5:0]  idx;
    logic [7:0]  ver_ihl;
    logic [15:0] totlen;
    logic [15:0] ident;
    logic [13:0] frag;
    logic [7:0]  proto;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] pcnt;

    logic        s_fire;
    logic        hdr_byte;
    logic        hdr_end;
    logic        pass;
    logic        csum_ok;
    logic        last_hit;
    logic        empty_l4;
    logic [3:0]  ihl;
    logic [5:0]  hlen;
    logic [5:0]  end_idx;
    logic [31:0] dst_cur;
    logic [15:0] l4_len;

    assign ihl      = ver_ihl[3:0];
    assign hlen     = {ihl, 2'b00};
    assign end_idx  = (ihl < IHL_MIN) ? HDR_LAST : hlen - 6'd1;
    assign s_ready  = (state == ST_PAY) ? (!m_valid || m_ready) : 1'b1;
    assign s_fire   = s_valid && s_ready;
    assign hdr_byte = s_fire && (state == ST_HDR);
    assign hdr_end  = hdr_byte && (idx == end_idx);
    assign dst_cur  = (idx == HDR_LAST) ? {dst[23:0], s_data} : dst;
    assign l4_len   = totlen - {10'd0, hlen};
    assign empty_l4 = (l4_len == 16'd0);
    assign last_hit = ((pcnt + 16'd1) == hdr_l4_len);

    assign pass = (ver_ihl[7:4] == IPV4_VERSION)
               && (ihl >= IHL_MIN)
               && (totlen >= 16'd20)
               && (totlen <= MAX_LEN)
               && (totlen >= {10'd0, hlen})
               && (frag == 14'd0)
               && (proto == PROTOCOL)
               && (dst_cur == DESADDR)
               && (!SRC_FILT || (src == SRCADDR))
               && csum_ok;

`ifdef IP_RX_CSUM_CHECK_EN
    ip_csum_acc u_csum (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state == ST_IDLE),
        .en     (s_fire && (state == ST_IDLE || state == ST_HDR)),
        .data   (s_data),
        .sum_ok (csum_ok)
    );
`else
    assign csum_ok = 1'b1;
`endif

    // Capture the fixed header fields by byte index; options are skipped
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ver_ihl <= 8'd0;
            totlen  <= 16'd0;
            ident   <= 16'd0;
            frag    <= 14'd0;
            proto   <= 8'd0;
            src     <= 32'd0;
            dst     <= 32'd0;
        end else if (s_fire && state == ST_IDLE) begin
            ver_ihl <= s_data;
        end else if (hdr_byte) begin
            unique case (1'b1)
                (idx == OFF_TOTLEN || idx == OFF_TOTLEN + 6'd1):
                    totlen <= {totlen[7:0], s_data};
                (idx == OFF_IDENT || idx == OFF_IDENT + 6'd1):
                    ident <= {ident[7:0], s_data};
                (idx == OFF_FLAGS || idx == OFF_FLAGS + 6'd1):
                    frag <= {frag[5:0], s_data};
                (idx == OFF_PROTO):
                    proto <= s_data;
                (idx >= OFF_SRC && idx < OFF_DST):
                    src <= {src[23:0], s_data};
                (idx >= OFF_DST && idx <= HDR_LAST):
                    dst <= {dst[23:0], s_data};
                default: ;
            endcase
        end
    end

    // Packet FSM, output register, sideband and counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= 6'd0;
            pcnt       <= 16'd0;
            m_data     <= 8'd0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            m_err      <= 1'b0;
            hdr_valid  <= 1'b0;
            hdr_src    <= 32'd0;
            hdr_ident  <= 16'd0;
            hdr_l4_len <= 16'd0;
            ok_cnt     <= 16'd0;
            drop_cnt   <= 16'd0;
        end else begin
            hdr_valid <= 1'b0;
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
                m_err   <= 1'b0;
            end
            unique case (state)
                ST_IDLE: begin
                    if (s_fire) begin
                        idx <= 6'd1;
                        if (s_last) drop_cnt <= sat_inc(drop_cnt);
                        else state <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (s_fire) begin
                        idx <= idx + 6'd1;
                        if (s_last && !(hdr_end && pass && empty_l4)) begin
                            drop_cnt <= sat_inc(drop_cnt);
                            state    <= ST_IDLE;
                        end else if (hdr_end && pass) begin
                            hdr_valid  <= 1'b1;
                            hdr_src    <= src;
                            hdr_ident  <= ident;
                            hdr_l4_len <= l4_len;
                            ok_cnt     <= sat_inc(ok_cnt);
                            pcnt       <= 16'd0;
                            if (!empty_l4) state <= ST_PAY;
                            else if (s_last) state <= ST_IDLE;
                            else state <= ST_DROP;
                        end else if (hdr_end) begin
                            drop_cnt <= sat_inc(drop_cnt);
                            state    <= ST_DROP;
                        end
                    end
                end
                ST_PAY: begin
                    if (s_fire) begin
                        m_data  <= s_data;
                        m_valid <= 1'b1;
                        m_last  <= last_hit || s_last;
                        m_err   <= s_last && !last_hit;
                        pcnt    <= pcnt + 16'd1;
                        if (last_hit) state <= s_last ? ST_IDLE : ST_DROP;
                        else if (s_last) state <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (s_fire && s_last) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ip_rx_stream_parser.sv
// tb_ip_rx_stream_parser: randomized packets vs. a frame-level reference
// model of the IPv4 receive parser; one task per scenario.
module tb_ip_rx_stream_parser;

    typedef logic [7:0] bq_t[$];

    localparam logic [31:0] DES = 32'hc0a84103;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_err;
    logic        m_ready;
    logic        hdr_valid;
    logic [31:0] hdr_src;
    logic [15:0] hdr_ident;
    logic [15:0] hdr_l4_len;
    logic [15:0] ok_cnt;
    logic [15:0] drop_cnt;

    int errors = 0;
    int checks = 0;

    logic [9:0]  got_q[$];
    logic [9:0]  exp_q[$];
    int          got_hdr = 0;
    int          exp_hdr = 0;
    logic [31:0] got_src;
    logic [15:0] got_ident;
    logic [15:0] got_l4;
    logic [31:0] exp_src;
    logic [15:0] exp_ident;
    logic [15:0] exp_l4;
    int          exp_ok = 0;
    int          exp_drop = 0;
    int          rdy_mode = 0;
    int          pay_lo = 0;
    int          pay_hi = 0;
    int          stall_viol = 0;

    always #5 clk = ~clk;

    ip_rx_stream_parser dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_err      (m_err),
        .m_ready    (m_ready),
        .hdr_valid  (hdr_valid),
        .hdr_src    (hdr_src),
        .hdr_ident  (hdr_ident),
        .hdr_l4_len (hdr_l4_len),
        .ok_cnt     (ok_cnt),
        .drop_cnt   (drop_cnt)
    );

    // Downstream ready pattern: 0 always, 1 toggle, else random
    initial begin
        m_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0: m_ready = 1'b1;
                1: m_ready = !m_ready;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Record output handshakes and header pulses mid-cycle
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (m_valid && m_ready) got_q.push_back({m_err, m_last, m_data});
            if (hdr_valid) begin
                got_hdr++;
                got_src = hdr_src;
                got_ident = hdr_ident;
                got_l4 = hdr_l4_len;
            end
        end
    end

    function automatic logic [15:0] hdr_sum(input bq_t f, input int hl);
        int unsigned s = 0;
        for (int i = 0; i + 1 < hl; i += 2) s += {16'd0, f[i], f[i+1]};
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        return s[15:0];
    endfunction

    function automatic bq_t make_pkt(input int ihl, input int tl,
                                     input logic [7:0] proto,
                                     input logic [31:0] dst,
                                     input logic [7:0] fl, input int nbytes);
        bq_t f;
        logic [15:0] id;
        logic [31:0] src;
        logic [15:0] cs;
        id = 16'($urandom);
        src = $urandom;
        for (int i = 0; i < nbytes; i++) f.push_back(8'($urandom));
        f[0] = {4'd4, ihl[3:0]};
        f[1] = 8'd0;
        f[2] = tl[15:8];
        f[3] = tl[7:0];
        f[4] = id[15:8];
        f[5] = id[7:0];
        f[6] = fl;
        f[7] = 8'd0;
        f[8] = 8'd64;
        f[9] = proto;
        f[10] = 8'd0;
        f[11] = 8'd0;
        for (int i = 0; i < 4; i++) begin
            f[12+i] = src[31-8*i -: 8];
            f[16+i] = dst[31-8*i -: 8];
        end
        cs = ~hdr_sum(f, ihl * 4);
        f[10] = cs[15:8];
        f[11] = cs[7:0];
        return f;
    endfunction

    // Frame-level reference: decide accept/drop and the L4 beats expected
    function automatic void model(input bq_t f);
        int n;
        int ihl;
        int hl;
        int hend;
        int tl;
        int l4;
        int avail;
        int k;
        logic ok;
        logic e;
        n = f.size();
        ihl = int'(f[0][3:0]);
        hl = ihl * 4;
        hend = (ihl < 5) ? 20 : hl;
        if (n < hend) begin
            exp_drop++;
            return;
        end
        tl = int'({f[2], f[3]});
        l4 = tl - hl;
        ok = (f[0][7:4] == 4'd4) && (ihl >= 5) && (tl >= 20) && (tl <= 1500)
          && (tl >= hl) && (f[6][5] == 1'b0) && ({f[6][4:0], f[7]} == 13'd0)
          && (f[9] == 8'd6) && ({f[16], f[17], f[18], f[19]} == DES);
`ifdef IP_RX_CSUM_CHECK_EN
        if (ok) ok = (hdr_sum(f, hl) == 16'hFFFF);
`endif
        if (!ok || (n == hend && l4 != 0)) begin
            exp_drop++;
            return;
        end
        exp_ok++;
        exp_hdr++;
        exp_src = {f[12], f[13], f[14], f[15]};
        exp_ident = {f[4], f[5]};
        exp_l4 = 16'(l4);
        avail = n - hl;
        k = (avail < l4) ? avail : l4;
        e = (avail < l4);
        for (int j = 0; j < k; j++)
            exp_q.push_back({e && (j == k - 1), 1'(j == k - 1), f[hl+j]});
    endfunction

    function automatic int beats_diff();
        int d = 0;
        if (got_q.size() != exp_q.size()) d++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) d++;
        return d;
    endfunction

    task automatic drive(input bq_t f, input int nsend, input int gaps);
        for (int i = 0; i < nsend; i++) begin
            int w = 0;
            if (gaps != 0 && $urandom_range(0, 3) == 0) begin
                @(negedge clk);
                s_valid = 1'b0;
                s_last = 1'b0;
            end
            @(negedge clk);
            s_valid = 1'b1;
            s_data = f[i];
            s_last = (i == f.size() - 1);
            #1;
            if (i >= pay_lo && i < pay_hi && s_ready !== (!m_valid || m_ready))
                stall_viol++;
            while (!s_ready && w < 200) begin
                @(negedge clk);
                #1;
                if (i >= pay_lo && i < pay_hi && s_ready !== (!m_valid || m_ready))
                    stall_viol++;
                w++;
            end
            checks++;
            if (w >= 200) begin
                errors++;
                $display("FAIL drive_timeout byte=%0d s_ready=%0b exp=1", i, s_ready);
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        repeat (3) @(negedge clk);
        while (m_valid === 1'b1 && w < 500) begin
            @(negedge clk);
            w++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run(input bq_t f, input int gaps);
        model(f);
        drive(f, f.size(), gaps);
        drain();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        s_valid = 1'b0;
        s_last = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        got_q.delete();
        exp_q.delete();
        got_hdr = 0;
        exp_hdr = 0;
        exp_ok = 0;
        exp_drop = 0;
        pay_lo = 0;
        pay_hi = 0;
        rdy_mode = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_valid = 1'b0;
        s_last = 1'b0;
        s_data = 8'd0;
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if ({m_valid, m_last, m_err, hdr_valid} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=0000", {m_valid, m_last, m_err, hdr_valid});
        end
        checks++;
        if ({ok_cnt, drop_cnt, hdr_src, hdr_ident, hdr_l4_len} !== 96'd0) begin
            errors++;
            $display("FAIL reset_regs ok=%0d drop=%0d l4=%0d exp=0", ok_cnt, drop_cnt, hdr_l4_len);
        end
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_s_ready got=%b exp=1", s_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        bq_t f;
        do_reset();
        f = make_pkt(5, 60, 8'd6, DES, 8'h00, 60);
        run(f, 0);
        checks++;
        if (got_q.size() !== 40) begin
            errors++;
            $display("FAIL basic_beats got=%0d exp=40", got_q.size());
        end
        checks++;
        if (beats_diff() !== 0) begin
            errors++;
            $display("FAIL basic_data diffs=%0d exp=0", beats_diff());
        end
        checks++;
        if (got_q.size() != 40 || got_q[39][9:8] !== 2'b01) begin
            errors++;
            $display("FAIL basic_last got_beats=%0d exp_last_on=40", got_q.size());
        end
        checks++;
        if (ok_cnt !== 16'd1 || got_hdr !== 1) begin
            errors++;
            $display("FAIL basic_ok ok_cnt=%0d hdr=%0d exp=1", ok_cnt, got_hdr);
        end
        checks++;
        if (got_l4 !== 16'd40 || got_ident !== exp_ident || got_src !== exp_src) begin
            errors++;
            $display("FAIL basic_hdr l4=%0d ident=%h exp l4=40 ident=%h", got_l4, got_ident, exp_ident);
        end
    endtask

    task automatic test_csum();
        bq_t f;
        do_reset();
        f = make_pkt(5, 60, 8'd6, DES, 8'h00, 60);
        f[10] = ~f[10];
        run(f, 0);
        checks++;
`ifdef IP_RX_CSUM_CHECK_EN
        if (got_q.size() !== 0 || drop_cnt !== 16'd1) begin
            errors++;
            $display("FAIL csum_drop beats=%0d drop=%0d exp 0/1", got_q.size(), drop_cnt);
        end
`else
        if (got_q.size() !== 40 || ok_cnt !== 16'd1) begin
            errors++;
            $display("FAIL csum_accept beats=%0d ok=%0d exp 40/1", got_q.size(), ok_cnt);
        end
`endif
        checks++;
        if (beats_diff() !== 0 || drop_cnt !== 16'(exp_drop)) begin
            errors++;
            $display("FAIL csum_model diffs=%0d drop=%0d exp 0/%0d", beats_diff(), drop_cnt, exp_drop);
        end
    endtask

    task automatic test_options();
        bq_t f;
        do_reset();
        f = make_pkt(6, 64, 8'd6, DES, 8'h00, 64);
        run(f, 0);
        checks++;
        if (got_l4 !== 16'd40 || got_hdr !== 1) begin
            errors++;
            $display("FAIL opt_l4 got=%0d exp=40", got_l4);
        end
        checks++;
        if (got_q.size() == 0 || got_q[0][7:0] !== f[24]) begin
            errors++;
            $display("FAIL opt_first beats=%0d exp_byte=%h", got_q.size(), f[24]);
        end
        checks++;
        if (beats_diff() !== 0 || got_q.size() !== 40) begin
            errors++;
            $display("FAIL opt_data diffs=%0d beats=%0d exp 0/40", beats_diff(), got_q.size());
        end
    endtask

    task automatic test_backpressure();
        bq_t f;
        do_reset();
        rdy_mode = 1;
        stall_viol = 0;
        pay_lo = 20;
        pay_hi = 60;
        f = make_pkt(5, 60, 8'd6, DES, 8'h00, 60);
        run(f, 0);
        pay_lo = 0;
        pay_hi = 0;
        rdy_mode = 0;
        checks++;
        if (got_q.size() !== 40 || beats_diff() !== 0) begin
            errors++;
            $display("FAIL bp_data beats=%0d diffs=%0d exp 40/0", got_q.size(), beats_diff());
        end
        checks++;
        if (stall_viol !== 0) begin
            errors++;
            $display("FAIL bp_s_ready violations=%0d exp=0", stall_viol);
        end
    endtask

    task automatic test_truncated();
        bq_t f;
        do_reset();
        f = make_pkt(5, 60, 8'd6, DES, 8'h00, 50);
        run(f, 0);
        checks++;
        if (got_q.size() !== 30 || beats_diff() !== 0) begin
            errors++;
            $display("FAIL trunc_data beats=%0d diffs=%0d exp 30/0", got_q.size(), beats_diff());
        end
        checks++;
        if (got_q.size() != 30 || got_q[29][9:8] !== 2'b11) begin
            errors++;
            $display("FAIL trunc_err beats=%0d exp last+err on 30", got_q.size());
        end
    endtask

    task automatic test_padding();
        bq_t f;
        do_reset();
        f = make_pkt(5, 46, 8'd6, DES, 8'h00, 60);
        run(f, 0);
        checks++;
        if (got_q.size() !== 26 || beats_diff() !== 0) begin
            errors++;
            $display("FAIL pad_data beats=%0d diffs=%0d exp 26/0", got_q.size(), beats_diff());
        end
        checks++;
        if (got_q.size() != 26 || got_q[25][9:8] !== 2'b01 || ok_cnt !== 16'd1) begin
            errors++;
            $display("FAIL pad_last beats=%0d ok=%0d exp 26/1", got_q.size(), ok_cnt);
        end
    endtask

    task automatic test_filters();
        bq_t f;
        do_reset();
        f = make_pkt(5, 60, 8'd17, DES, 8'h00, 60);
        run(f, 0);
        f = make_pkt(5, 60, 8'd6, 32'hc0a84105, 8'h00, 60);
        run(f, 0);
        f = make_pkt(5, 60, 8'd6, DES, 8'h20, 60);
        run(f, 0);
        checks++;
        if (drop_cnt !== 16'd3 || got_q.size() !== 0 || got_hdr !== 0) begin
            errors++;
            $display("FAIL filt_drop drop=%0d beats=%0d hdr=%0d exp 3/0/0", drop_cnt, got_q.size(), got_hdr);
        end
        f = make_pkt(5, 1501, 8'd6, DES, 8'h00, 1501);
        run(f, 0);
        checks++;
        if (drop_cnt !== 16'd4 || got_q.size() !== 0) begin
            errors++;
            $display("FAIL filt_maxlen drop=%0d beats=%0d exp 4/0", drop_cnt, got_q.size());
        end
        f = make_pkt(5, 1500, 8'd6, DES, 8'h00, 1500);
        run(f, 0);
        checks++;
        if (got_q.size() !== 1480 || beats_diff() !== 0 || ok_cnt !== 16'd1) begin
            errors++;
            $display("FAIL filt_len1500 beats=%0d ok=%0d exp 1480/1", got_q.size(), ok_cnt);
        end
    endtask

    task automatic test_random();
        bq_t f;
        do_reset();
        for (int p = 0; p < 30; p++) begin
            int r;
            int ihl;
            int l4;
            int tl;
            int n;
            logic [7:0] pr;
            logic [31:0] da;
            logic [7:0] fl;
            r = $urandom_range(0, 11);
            ihl = $urandom_range(5, 7);
            l4 = $urandom_range(1, 40);
            tl = ihl * 4 + l4;
            n = tl;
            pr = (r == 0) ? 8'd17 : 8'd6;
            da = (r == 1) ? 32'hc0a84105 : DES;
            fl = (r == 2) ? 8'h20 : 8'h00;
            if (r == 4) n = ihl * 4 + $urandom_range(0, l4 - 1);
            if (r == 5) n = tl + $urandom_range(1, 20);
            f = make_pkt(ihl, tl, pr, da, fl, (n > tl) ? n : tl);
            if (r == 3) f[11] = f[11] ^ 8'h10;
            if (r == 6) n = $urandom_range(1, ihl * 4 - 1);
            while (f.size() > n) void'(f.pop_back());
            rdy_mode = $urandom_range(0, 2);
            model(f);
            drive(f, f.size(), 1);
            if ($urandom_range(0, 1) == 1) drain();
        end
        drain();
        rdy_mode = 0;
        checks++;
        if (beats_diff() !== 0) begin
            errors++;
            $display("FAIL rand_data diffs=%0d beats=%0d exp_beats=%0d", beats_diff(), got_q.size(), exp_q.size());
        end
        checks++;
        if (ok_cnt !== 16'(exp_ok) || drop_cnt !== 16'(exp_drop)) begin
            errors++;
            $display("FAIL rand_cnt ok=%0d drop=%0d exp %0d/%0d", ok_cnt, drop_cnt, exp_ok, exp_drop);
        end
        checks++;
        if (got_hdr !== exp_hdr || (exp_hdr > 0 && (got_l4 !== exp_l4 || got_src !== exp_src))) begin
            errors++;
            $display("FAIL rand_hdr pulses=%0d l4=%0d exp %0d/%0d", got_hdr, got_l4, exp_hdr, exp_l4);
        end
    endtask

    task automatic test_reset_mid();
        bq_t f;
        do_reset();
        f = make_pkt(5, 60, 8'd6, DES, 8'h00, 60);
        drive(f, 30, 0);
        rst_n = 1'b0;
        @(negedge clk);
        #2;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_outputs m_valid=%b s_ready=%b exp 0/1", m_valid, s_ready);
        end
        checks++;
        if (ok_cnt !== 16'd0 || hdr_l4_len !== 16'd0) begin
            errors++;
            $display("FAIL rstmid_regs ok=%0d l4=%0d exp 0/0", ok_cnt, hdr_l4_len);
        end
        rst_n = 1'b1;
        got_q.delete();
        exp_q.delete();
        got_hdr = 0;
        exp_hdr = 0;
        f = make_pkt(5, 60, 8'd6, DES, 8'h00, 60);
        run(f, 0);
        checks++;
        if (got_q.size() !== 40 || beats_diff() !== 0 || ok_cnt !== 16'd1) begin
            errors++;
            $display("FAIL rstmid_after beats=%0d ok=%0d exp 40/1", got_q.size(), ok_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_csum();
        test_options();
        test_backpressure();
        test_truncated();
        test_padding();
        test_filters();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
